// File: rtl/fetch_stage.sv
// RV32I IF stage: PC register, single-outstanding instruction fetch and IF/ID register.
// Optional perf counters (fetch_cnt, kill_cnt) enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_Write,
    input  logic        IF_ID_Write,
    input  logic        PCSrc_E,
    input  logic [31:0] PC_Target_E,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Ins_D,
    output logic [31:0] PC_D,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] PC_4D,
    output logic [31:0] fetch_cnt,
    output logic [15:0] kill_cnt
`else
    output logic [31:0] PC_4D
`endif
);

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_KILL, S_HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt, w_pc_4, w_tgt;
    logic [31:0] r_hold_ins;
    logic        w_adv, w_req, w_load, w_hold_cap;
    logic [31:0] w_addr, w_load_ins;

    assign w_adv  = PC_Write & IF_ID_Write;
    assign w_pc_4 = r_pc + 32'd4;
    assign w_tgt  = PC_Target_E & ~32'd3;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req       = 1'b0;
        w_addr      = r_pc;
        w_load      = 1'b0;
        w_load_ins  = imem_rdata;
        w_hold_cap  = 1'b0;
        unique case (r_state)
            S_ISSUE: begin
                w_req       = 1'b1;
                w_state_nxt = S_WAIT;
                if (PCSrc_E) begin
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = S_KILL;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (PCSrc_E) begin
                        w_pc_nxt = w_tgt;
                        w_req    = 1'b1;
                        w_addr   = w_tgt;
                    end else if (w_adv) begin
                        // back-to-back issue keeps one instruction per cycle at latency 1
                        w_load   = 1'b1;
                        w_pc_nxt = w_pc_4;
                        w_req    = 1'b1;
                        w_addr   = w_pc_4;
                    end else begin
                        w_hold_cap  = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (PCSrc_E) begin
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = S_KILL;
                end
            end
            S_KILL: begin
                if (PCSrc_E) w_pc_nxt = w_tgt;
                if (imem_rvalid) begin
                    w_req       = 1'b1;
                    w_addr      = PCSrc_E ? w_tgt : r_pc;
                    w_state_nxt = S_WAIT;
                end
            end
            S_HOLD: begin
                if (PCSrc_E) begin
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = S_ISSUE;
                end else if (w_adv) begin
                    w_load      = 1'b1;
                    w_load_ins  = r_hold_ins;
                    w_pc_nxt    = w_pc_4;
                    w_state_nxt = S_ISSUE;
                end
            end
            default: w_state_nxt = S_ISSUE;
        endcase
    end

    assign imem_req  = w_req & rst_n;
    assign imem_addr = w_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_ISSUE;
            r_pc       <= RESET_PC;
            r_hold_ins <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_hold_cap) r_hold_ins <= imem_rdata;
        end
    end

    // Flush beats stall; PC fields keep their value on flush or bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Ins_D <= NOP_INS;
            PC_D  <= '0;
            PC_4D <= '0;
        end else if (PCSrc_E) begin
            Ins_D <= NOP_INS;
        end else if (IF_ID_Write) begin
            if (w_load) begin
                Ins_D <= w_load_ins;
                PC_D  <= r_pc;
                PC_4D <= w_pc_4;
            end else begin
                Ins_D <= NOP_INS;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic w_kill;

    assign w_kill = (imem_rvalid & ((r_state == S_KILL) | ((r_state == S_WAIT) & PCSrc_E)))
                  | ((r_state == S_HOLD) & PCSrc_E);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            if (w_load && !PCSrc_E && IF_ID_Write) fetch_cnt <= fetch_cnt + 32'd1;
            if (w_kill) kill_cnt <= kill_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one stimulus vector per clock, expected values hand-derived.
// Perf-counter checks are included when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PC_Write, IF_ID_Write, PCSrc_E, imem_rvalid;
    logic [31:0] PC_Target_E, imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr, Ins_D, PC_D, PC_4D;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [15:0] kill_cnt;
`endif

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INS(NOP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PC_Write    (PC_Write),
        .IF_ID_Write (IF_ID_Write),
        .PCSrc_E     (PCSrc_E),
        .PC_Target_E (PC_Target_E),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Ins_D       (Ins_D),
        .PC_D        (PC_D),
`ifdef FETCH_PERF_CNT_EN
        .PC_4D       (PC_4D),
        .fetch_cnt   (fetch_cnt),
        .kill_cnt    (kill_cnt)
`else
        .PC_4D       (PC_4D)
`endif
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive one cycle's inputs just after the falling edge; the caller then sees
    // this cycle's combinational outputs and the IF/ID state from the previous edge.
    task automatic cyc(input logic pw, input logic iw, input logic ps, input logic [31:0] tg,
                       input logic rv, input logic [31:0] rd);
        @(negedge clk);
        PC_Write    = pw;
        IF_ID_Write = iw;
        PCSrc_E     = ps;
        PC_Target_E = tg;
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] pc4);
        check({tag, ".ins"}, Ins_D, ins);
        check({tag, ".pc"}, PC_D, pc);
        check({tag, ".pc4"}, PC_4D, pc4);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        PC_Write = 1'b0; IF_ID_Write = 1'b0; PCSrc_E = 1'b0;
        PC_Target_E = '0; imem_rvalid = 1'b0; imem_rdata = '0;
        @(negedge clk); #1;
        check("rst.req", {31'd0, imem_req}, 32'd0);
        chk_id("rst", NOP, 32'd0, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // latency-1 streaming
        cyc(1, 1, 0, 0, 0, 0);
        check("c1.req", {31'd0, imem_req}, 32'd1);
        check("c1.addr", imem_addr, 32'd0);
        cyc(1, 1, 0, 0, 1, mem(32'd0));
        check("c2.addr", imem_addr, 32'd4);
        check("c2.ins", Ins_D, NOP);
        cyc(1, 1, 0, 0, 1, mem(32'd4));
        check("c3.addr", imem_addr, 32'd8);
        chk_id("c3", mem(32'd0), 32'd0, 32'd4);
        cyc(1, 1, 0, 0, 1, mem(32'd8));
        check("c4.addr", imem_addr, 32'd12);
        chk_id("c4", mem(32'd4), 32'd4, 32'd8);

        // latency-3 responses
        cyc(1, 1, 0, 0, 0, 0);
        check("c5.req", {31'd0, imem_req}, 32'd0);
        chk_id("c5", mem(32'd8), 32'd8, 32'd12);
        cyc(1, 1, 0, 0, 0, 0);
        check("c6.req", {31'd0, imem_req}, 32'd0);
        chk_id("c6", NOP, 32'd8, 32'd12);
        cyc(1, 1, 0, 0, 1, mem(32'd12));
        check("c7.addr", imem_addr, 32'd16);
        check("c7.ins", Ins_D, NOP);
        cyc(1, 1, 0, 0, 0, 0);
        check("c8.req", {31'd0, imem_req}, 32'd0);
        chk_id("c8", mem(32'd12), 32'd12, 32'd16);
        cyc(1, 1, 0, 0, 0, 0);
        check("c9.ins", Ins_D, NOP);
        cyc(1, 1, 0, 0, 1, mem(32'd16));
        check("c10.addr", imem_addr, 32'd20);

        // stall: response for 20 arrives while frozen
        cyc(0, 0, 0, 0, 1, mem(32'd20));
        check("c11.req", {31'd0, imem_req}, 32'd0);
        chk_id("c11", mem(32'd16), 32'd16, 32'd20);
        cyc(0, 0, 0, 0, 0, 0);
        check("c12.req", {31'd0, imem_req}, 32'd0);
        chk_id("c12", mem(32'd16), 32'd16, 32'd20);
        cyc(1, 1, 0, 0, 0, 0);
        chk_id("c13", mem(32'd16), 32'd16, 32'd20);
        cyc(1, 1, 0, 0, 0, 0);
        check("c14.req", {31'd0, imem_req}, 32'd1);
        check("c14.addr", imem_addr, 32'd24);
        chk_id("c14", mem(32'd20), 32'd20, 32'd24);

        // redirect while waiting, stale response discarded
        cyc(1, 1, 1, 32'h100, 0, 0);
        check("c15.req", {31'd0, imem_req}, 32'd0);
        cyc(1, 1, 0, 0, 1, mem(32'd24));
        check("c16.addr", imem_addr, 32'h100);
        chk_id("c16", NOP, 32'd20, 32'd24);
        cyc(1, 1, 0, 0, 1, mem(32'h100));
        check("c17.addr", imem_addr, 32'h104);
        check("c17.ins", Ins_D, NOP);

        // redirect coinciding with rvalid and stall: flush wins, same-cycle reissue
        cyc(0, 0, 1, 32'h100, 1, mem(32'h104));
        check("c18.req", {31'd0, imem_req}, 32'd1);
        check("c18.addr", imem_addr, 32'h100);
        chk_id("c18", mem(32'h100), 32'h100, 32'h104);
        cyc(1, 1, 0, 0, 0, 0);
        check("c19.req", {31'd0, imem_req}, 32'd0);
        chk_id("c19", NOP, 32'h100, 32'h104);

        // misaligned target and PC wrap
        cyc(1, 1, 1, 32'hFFFF_FFFE, 0, 0);
        cyc(1, 1, 0, 0, 1, mem(32'h100));
        check("c21.addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 0, 1, mem(32'hFFFF_FFFC));
        check("c22.addr", imem_addr, 32'h0);
        cyc(1, 1, 0, 0, 0, 0);
        chk_id("c23", mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, 32'd8);
        check("kill_cnt", {16'd0, kill_cnt}, 32'd3);
`endif

        // reset mid-request, late rvalid in S_ISSUE ignored
        rst_n = 1'b0;
        #1;
        check("rst2.req", {31'd0, imem_req}, 32'd0);
        chk_id("rst2", NOP, 32'd0, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst2.kill_cnt", {16'd0, kill_cnt}, 32'd0);
`endif
        @(posedge clk); #2 rst_n = 1'b1;
        cyc(1, 1, 0, 0, 1, 32'hDEAD_BEEF);
        check("c25.addr", imem_addr, 32'd0);
        cyc(1, 1, 0, 0, 0, 0);
        check("c26.req", {31'd0, imem_req}, 32'd0);
        chk_id("c26", NOP, 32'd0, 32'd0);
        cyc(1, 1, 0, 0, 1, mem(32'd0));
        check("c27.addr", imem_addr, 32'd4);
        cyc(1, 1, 0, 0, 0, 0);
        chk_id("c28", mem(32'd0), 32'd0, 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
